// File: rtl/gf_inv_128_pkg.sv
// gf128_pkg: shared constants and FSM state type for the GF(2^128) inverter and multiplier.
package gf128_pkg;
   localparam int GF128_W = 128;
   localparam logic [GF128_W-1:0] GF128_POLY_LO = 128'h87;
   localparam int GF_INV_PAIRS = 126;
   localparam int C_G1_W = 22;
   localparam logic [6:0] GF_INV_CNT_LAST = 7'(GF_INV_PAIRS - 1);
   typedef enum logic [2:0] {ST_IDLE, ST_SQR, ST_MUL, ST_FIN, ST_DONE} gf_inv_state_t;
endpackage

// File: rtl/gf_inv_128_if.sv
// gf_inv_128_if: operand/result handshake bundle for gf_inv_128.
// Carries zero_err only when GF_INV_ZERO_FLAG_EN is defined.
interface gf_inv_128_if;
   import gf128_pkg::*;
   logic in_valid, in_ready, out_valid, out_ready;
   logic [GF128_W-1:0] a, y;
   logic [C_G1_W-1:0] C_g1;
`ifdef GF_INV_ZERO_FLAG_EN
   logic zero_err;
   modport master(output in_valid, a, C_g1, out_ready, input in_ready, out_valid, y, zero_err);
   modport slave(input in_valid, a, C_g1, out_ready, output in_ready, out_valid, y, zero_err);
`else
   modport master(output in_valid, a, C_g1, out_ready, input in_ready, out_valid, y);
   modport slave(input in_valid, a, C_g1, out_ready, output in_ready, out_valid, y);
`endif
endinterface

// File: rtl/gf_inv_128_mul.sv
// gf_mul_128_0: combinational GF(2^128) multiplier, poly x^128+x^7+x^2+x+1, bit i = coeff of x^i.
module gf_mul_128_0 import gf128_pkg::*; (
   input  logic               rst_n,
   input  logic [C_G1_W-1:0]  C_g1_i,
   input  logic [GF128_W-1:0] a_i,
   input  logic [GF128_W-1:0] b_i,
   output logic [GF128_W-1:0] p_o
);
   logic [GF128_W-1:0] p, v;
   logic unused_cfg;
   assign unused_cfg = ^{rst_n, C_g1_i};
   // shift-and-add: v walks through b*x^i reduced modulo the field polynomial
   always_comb begin
      p = '0;
      v = b_i;
      for (int i = 0; i < GF128_W; i++) begin
         if (a_i[i]) p = p ^ v;
         v = {v[GF128_W-2:0], 1'b0} ^ (v[GF128_W-1] ? GF128_POLY_LO : '0);
      end
   end
   assign p_o = p;
endmodule

// File: rtl/gf_inv_128.sv
// gf_inv_128: Fermat inverter y = a^(2^128-2) using one time-shared gf_mul_128_0.
// Optional zero-operand flag enabled by GF_INV_ZERO_FLAG_EN.
module gf_inv_128 import gf128_pkg::*; (
   input logic clk,
   input logic rst_n,
   gf_inv_128_if.slave io
);
   gf_inv_state_t state_q, state_d;
   logic [GF128_W-1:0] base_q, base_d, x_q, x_d, prod;
   logic [6:0] cnt_q, cnt_d;
   gf_mul_128_0 u_mul (
      .rst_n  (rst_n),
      .C_g1_i (io.C_g1),
      .a_i    (x_q),
      .b_i    (state_q == ST_MUL ? base_q : x_q),
      .p_o    (prod)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         x_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
      end
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (io.in_valid) begin
            base_d  = io.a;
            x_d     = io.a;
            cnt_d   = '0;
            state_d = ST_SQR;
         end
         ST_SQR: begin
            x_d     = prod;
            state_d = ST_MUL;
         end
         ST_MUL: begin
            x_d     = prod;
            cnt_d   = cnt_q + 7'd1;
            state_d = cnt_q == GF_INV_CNT_LAST ? ST_FIN : ST_SQR;
         end
         ST_FIN: begin
            x_d     = prod;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = io.out_ready ? ST_IDLE : ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end
   assign io.in_ready  = state_q == ST_IDLE;
   assign io.out_valid = state_q == ST_DONE;
   assign io.y         = io.out_valid ? x_q : '0;
`ifdef GF_INV_ZERO_FLAG_EN
   logic zf_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) zf_q <= 1'b0;
      else if (state_q == ST_IDLE && io.in_valid) zf_q <= io.a == '0;
      else if (state_q == ST_DONE && io.out_ready) zf_q <= 1'b0;
   assign io.zero_err = zf_q & io.out_valid;
`endif
endmodule

// File: tb/tb_gf_inv_128.sv
// tb_gf_inv_128: directed and randomized self-checking bench for gf_inv_128.
module tb_gf_inv_128;
   import gf128_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0;
   int tests = 0, fails = 0;
   gf_inv_128_if io();
   gf_inv_128 dut (.clk(clk), .rst_n(rst_n), .io(io));
   always #5 clk = ~clk;

   function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] r = '0;
      for (int i = 127; i >= 0; i--) begin
         r = {r[126:0], 1'b0} ^ (r[127] ? 128'h87 : 128'h0);
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   task automatic start_op(input logic [127:0] av, output int lat);
      int n = 0;
      while (!io.in_ready && n < 10) begin @(posedge clk); #1; n++; end
      if (!io.in_ready) begin tests++; fails++; $display("FAIL start: in_ready=0 required 1"); end
      io.a = av;
      io.in_valid = 1'b1;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      n = 0;
      while (!io.out_valid && n < 400) begin @(posedge clk); #1; n++; end
      lat = n;
   endtask

   task automatic handshake();
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      tests++; if (io.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", io.in_ready); end
      tests++; if (io.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", io.out_valid); end
      tests++; if (io.y !== 128'h0) begin fails++; $display("FAIL reset_y: got %h want 0", io.y); end
`ifdef GF_INV_ZERO_FLAG_EN
      tests++; if (io.zero_err !== 1'b0) begin fails++; $display("FAIL reset_zero_err: got %b want 0", io.zero_err); end
`endif
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_one();
      int lat;
      start_op(128'h1, lat);
      tests++; if (lat != 253) begin fails++; $display("FAIL one_latency: got %0d want 253", lat); end
      tests++; if (io.y !== 128'h1) begin fails++; $display("FAIL one_y: got %h want 1", io.y); end
`ifdef GF_INV_ZERO_FLAG_EN
      tests++; if (io.zero_err !== 1'b0) begin fails++; $display("FAIL one_zero_err: got %b want 0", io.zero_err); end
`endif
      handshake();
      tests++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin fails++; $display("FAIL one_after_hs: in_ready=%b out_valid=%b want 1/0", io.in_ready, io.out_valid); end
   endtask

   task automatic test_x();
      int lat;
      start_op(128'h2, lat);
      tests++; if (lat != 253) begin fails++; $display("FAIL x_latency: got %0d want 253", lat); end
      tests++; if (io.y !== 128'h8000_0000_0000_0000_0000_0000_0000_0043) begin fails++; $display("FAIL x_y: got %h want 80..43", io.y); end
      handshake();
   endtask

   task automatic test_zero();
      int lat;
      start_op(128'h0, lat);
      tests++; if (lat != 253) begin fails++; $display("FAIL zero_latency: got %0d want 253", lat); end
      tests++; if (io.y !== 128'h0) begin fails++; $display("FAIL zero_y: got %h want 0", io.y); end
`ifdef GF_INV_ZERO_FLAG_EN
      tests++; if (io.zero_err !== 1'b1) begin fails++; $display("FAIL zero_flag: got %b want 1", io.zero_err); end
`endif
      handshake();
`ifdef GF_INV_ZERO_FLAG_EN
      tests++; if (io.zero_err !== 1'b0) begin fails++; $display("FAIL zero_flag_clear: got %b want 0", io.zero_err); end
`endif
   endtask

   task automatic test_backpressure();
      int lat;
      logic [127:0] want = 128'h8000_0000_0000_0000_0000_0000_0000_0043;
      start_op(128'h2, lat);
      io.a = 128'h1234;
      io.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tests++;
         if (io.out_valid !== 1'b1 || io.y !== want || io.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b y=%h want 1/0/%h", c, io.out_valid, io.in_ready, io.y, want);
         end
         @(posedge clk); #1;
      end
      io.in_valid = 1'b0;
      handshake();
      tests++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", io.in_ready, io.out_valid); end
   endtask

   task automatic test_reset_mid();
      int lat;
      io.a = 128'h1;
      io.in_valid = 1'b1;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      repeat (99) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++; if (io.out_valid !== 1'b0 || io.y !== 128'h0 || io.in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset: out_valid=%b y=%h in_ready=%b want 0/0/1", io.out_valid, io.y, io.in_ready); end
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      start_op(128'h2, lat);
      tests++; if (lat != 253 || io.y !== 128'h8000_0000_0000_0000_0000_0000_0000_0043) begin fails++; $display("FAIL mid_reset_next: lat=%0d y=%h want 253/80..43", lat, io.y); end
      handshake();
   endtask

   task automatic test_random();
      int lat;
      logic [127:0] av, p;
      for (int k = 0; k < 40; k++) begin
         av = {$urandom, $urandom, $urandom, $urandom};
         if (av == 128'h0) av = 128'h5;
         start_op(av, lat);
         p = ref_mul(av, io.y);
         tests++;
         if (lat != 253 || p !== 128'h1) begin
            fails++;
            $display("FAIL rand[%0d]: a=%h y=%h a*y=%h lat=%0d want 1/253", k, av, io.y, p, lat);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         handshake();
      end
   endtask

   initial begin
      io.in_valid = 1'b0;
      io.out_ready = 1'b0;
      io.a = '0;
      io.C_g1 = 22'h0;
      test_reset();
      test_one();
      test_x();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
